// File: rtl/key_entry_sequencer.sv
// Lock front end: synchronises and debounces three buttons, then sequences 4-digit
// code entry and issues single-cycle SAVE/CHECK strobes (or a timeout strobe).
module key_entry_sequencer #(
   parameter int DEB_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [2:0]  SW,
   input  logic        BTN_NEXT,
   input  logic        BTN_SAVE,
   input  logic        BTN_CHECK,
   output logic [11:0] CODE,
   output logic [2:0]  IDX,
   output logic        FULL,
   output logic        SAVE_P,
   output logic        CHECK_P,
   output logic        TO_P
);
   localparam int NB = 3;
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_FULL} state_t;

   logic [NB-1:0]         raw;
   logic [NB-1:0]         sync1_q, sync2_q, acc_q, acc_prev_q, pulse;
   logic [NB-1:0][DW-1:0] deb_cnt_q;
   logic                  nxt_p, sav_p, chk_p, any_p, expire;

   assign raw = {BTN_CHECK, BTN_SAVE, BTN_NEXT};

   // Bit order of every per-button vector: [0]=NEXT, [1]=SAVE, [2]=CHECK
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         acc_q      <= '0;
         acc_prev_q <= '0;
         deb_cnt_q  <= '0;
      end else begin
         sync1_q    <= raw;
         sync2_q    <= sync1_q;
         acc_prev_q <= acc_q;
         for (int b = 0; b < NB; b++) begin
            if (sync2_q[b] == acc_q[b]) begin
               deb_cnt_q[b] <= '0;
            end else if (deb_cnt_q[b] == DW'(DEB_CYCLES - 1)) begin
               acc_q[b]     <= sync2_q[b];
               deb_cnt_q[b] <= '0;
            end else begin
               deb_cnt_q[b] <= deb_cnt_q[b] + DW'(1);
            end
         end
      end
   end

   assign pulse = acc_q & ~acc_prev_q;
   assign nxt_p = pulse[0];
   assign sav_p = pulse[1];
   assign chk_p = pulse[2];
   assign any_p = |pulse;

   state_t         state_q, state_d;
   logic [11:0]    code_q, code_d;
   logic [2:0]     idx_q, idx_d;
   logic [TW-1:0]  tmr_q, tmr_d;
   logic           save_q, save_d, check_q, check_d, to_q, to_d;

   // A button pulse in the expiry cycle cancels the timeout
   assign expire = (state_q != S_IDLE) && (tmr_q == TW'(TIMEOUT_CYCLES - 1)) && !any_p;

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      idx_d   = idx_q;
      save_d  = 1'b0;
      check_d = 1'b0;
      to_d    = 1'b0;
      tmr_d   = (state_q == S_IDLE || any_p) ? '0 : tmr_q + TW'(1);
      case (state_q)
         S_IDLE: begin
            if (nxt_p) begin
               code_d  = {SW, 9'b0};
               idx_d   = 3'd1;
               state_d = S_ENTRY;
            end
         end
         S_ENTRY: begin
            if (nxt_p) begin
               case (idx_q)
                  3'd1:    code_d[8:6] = SW;
                  3'd2:    code_d[5:3] = SW;
                  default: code_d[2:0] = SW;
               endcase
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd3) state_d = S_FULL;
            end else if (expire) begin
               code_d  = '0;
               idx_d   = '0;
               to_d    = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_FULL: begin
            if (sav_p) begin
               save_d  = 1'b1;
               idx_d   = '0;
               state_d = S_IDLE;
            end else if (chk_p) begin
               check_d = 1'b1;
               idx_d   = '0;
               state_d = S_IDLE;
            end else if (expire) begin
               code_d  = '0;
               idx_d   = '0;
               to_d    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         code_q  <= '0;
         idx_q   <= '0;
         tmr_q   <= '0;
         save_q  <= 1'b0;
         check_q <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         idx_q   <= idx_d;
         tmr_q   <= tmr_d;
         save_q  <= save_d;
         check_q <= check_d;
         to_q    <= to_d;
      end
   end

   assign CODE    = code_q;
   assign IDX     = idx_q;
   assign FULL    = (state_q == S_FULL);
   assign SAVE_P  = save_q;
   assign CHECK_P = check_q;
   assign TO_P    = to_q;
endmodule
